// File: rtl/pulse_period_meter.sv
// Pulse period meter: measures the distance between consecutive rising edges of pulse_in
// in clock cycles. Define PULSE_PERIOD_METER_SYNC_EN to add a two-flop input synchroniser.
module pulse_period_meter #(
    parameter int MAX_PERIOD = 300000000,
    parameter int THRESH_0   = 25000000,
    parameter int THRESH_1   = 75000000,
    parameter int THRESH_2   = 150000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pulse_in,
    output logic [28:0] period,
    output logic        period_valid,
    output logic [1:0]  rate_class,
    output logic        timeout
);

    localparam logic [28:0] MAX_COUNT = 29'(MAX_PERIOD);
    localparam logic [28:0] LIMIT_0   = 29'(THRESH_0);
    localparam logic [28:0] LIMIT_1   = 29'(THRESH_1);
    localparam logic [28:0] LIMIT_2   = 29'(THRESH_2);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MEASURE   = 2'b01,
        TIMED_OUT = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [28:0] count_r;
    logic [28:0] count_next_s;
    logic [28:0] period_next_s;
    logic [1:0]  class_next_s;
    logic        valid_next_s;
    logic        timeout_next_s;
    logic        level_s;
    logic        armed_s;
    logic        prev_r;
    logic        edge_s;

    function automatic logic [1:0] classify(input logic [28:0] value);
        logic [1:0] cls;
        if (value < LIMIT_0) begin
            cls = 2'b00;
        end else if (value < LIMIT_1) begin
            cls = 2'b01;
        end else if (value < LIMIT_2) begin
            cls = 2'b10;
        end else begin
            cls = 2'b11;
        end
        return cls;
    endfunction

`ifdef PULSE_PERIOD_METER_SYNC_EN
    logic sync_a_r;
    logic sync_b_r;
    logic arm_a_r;
    logic arm_b_r;
    logic arm_c_r;

    // Two-flop synchroniser with a parallel "low seen since reset" pipeline of matching depth,
    // so a level already high at reset release never looks like an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a_r <= 1'b0;
            sync_b_r <= 1'b0;
            arm_a_r  <= 1'b0;
            arm_b_r  <= 1'b0;
            arm_c_r  <= 1'b0;
        end else begin
            sync_a_r <= pulse_in;
            sync_b_r <= sync_a_r;
            arm_a_r  <= arm_a_r | ~pulse_in;
            arm_b_r  <= arm_a_r;
            arm_c_r  <= arm_b_r;
        end
    end

    assign level_s = sync_b_r;
    assign armed_s = arm_c_r;
`else
    logic arm_r;

    // Arms edge detection once pulse_in has been sampled low after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            arm_r <= 1'b0;
        end else begin
            arm_r <= arm_r | ~pulse_in;
        end
    end

    assign level_s = pulse_in;
    assign armed_s = arm_r;
`endif

    // Previous sample of the edge-detect input.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign edge_s = level_s & ~prev_r & armed_s;

    // Next-state and next-output logic; the counter holds the length of the current interval.
    always_comb begin
        state_next_s   = state_r;
        count_next_s   = count_r;
        period_next_s  = period;
        class_next_s   = rate_class;
        valid_next_s   = 1'b0;
        timeout_next_s = timeout;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    state_next_s = MEASURE;
                    count_next_s = 29'd1;
                end else begin
                    count_next_s = 29'd0;
                end
            end
            MEASURE: begin
                if (edge_s) begin
                    period_next_s = count_r;
                    class_next_s  = classify(count_r);
                    valid_next_s  = 1'b1;
                    count_next_s  = 29'd1;
                end else if (count_r >= MAX_COUNT) begin
                    state_next_s   = TIMED_OUT;
                    timeout_next_s = 1'b1;
                    count_next_s   = MAX_COUNT;
                end else begin
                    count_next_s = count_r + 29'd1;
                end
            end
            TIMED_OUT: begin
                if (edge_s) begin
                    state_next_s   = MEASURE;
                    timeout_next_s = 1'b0;
                    count_next_s   = 29'd1;
                end else begin
                    count_next_s = MAX_COUNT;
                end
            end
            default: begin
                state_next_s   = IDLE;
                count_next_s   = 29'd0;
                timeout_next_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            count_r      <= 29'd0;
            period       <= 29'd0;
            rate_class   <= 2'b00;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            period       <= period_next_s;
            rate_class   <= class_next_s;
            period_valid <= valid_next_s;
            timeout      <= timeout_next_s;
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter; stimulus pushes expected reports, a monitor checks outputs.
// Works with or without PULSE_PERIOD_METER_SYNC_EN defined.
module tb_pulse_period_meter;

    localparam int MAX = 100;
`ifdef PULSE_PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        pulse_in;
    logic [28:0] period;
    logic        period_valid;
    logic [1:0]  rate_class;
    logic        timeout;

    typedef struct { int eff; int p; int c; } exp_t;
    typedef struct { bit is_reset; int eff; } evt_t;

    exp_t exp_q[$];
    evt_t evt_q[$];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    bit prev_v;
    bit prev_ok;
    bit have_prev;
    int last_k;

    pulse_period_meter #(
        .MAX_PERIOD(100),
        .THRESH_0(10),
        .THRESH_1(20),
        .THRESH_2(40)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pulse_in(pulse_in),
        .period(period),
        .period_valid(period_valid),
        .rate_class(rate_class),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    function automatic int cls_of(input int p);
        if (p < 10) return 0;
        if (p < 20) return 1;
        if (p < 40) return 2;
        return 3;
    endfunction

    task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at edge %0d: actual=%0d expected=%0d", name, n, act, exp);
        end
    endtask

    // One stimulus cycle; the reference model follows the rising-edge rules on sampled values.
    task automatic drive(input logic v, input logic r);
        int k;
        int gap;
        @(negedge clock);
        pulse_in = v;
        reset    = r;
        k = edge_n + 1;
        if (r) begin
            have_prev = 1'b0;
            prev_ok   = 1'b0;
            evt_q.push_back('{1'b1, k});
        end else begin
            if (v && prev_ok && !prev_v) begin
                gap = k - last_k;
                if (have_prev && gap <= MAX)
                    exp_q.push_back('{k + LAT, gap, cls_of(gap)});
                have_prev = 1'b1;
                last_k    = k;
                evt_q.push_back('{1'b0, k + LAT});
            end
            prev_ok = 1'b1;
        end
        prev_v = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive(1'b0, 1'b1);
        idle(3);
    endtask

    task automatic pulse(input int gap, input int width);
        repeat (width) drive(1'b1, 1'b0);
        repeat (gap - width) drive(1'b0, 1'b0);
    endtask

    // Monitor: applies due events, pops the expected report due this cycle and checks all outputs.
    initial begin : monitor
        int n;
        bit active;
        int last_eff;
        int held_p;
        int held_c;
        bit vexp;
        bit texp;
        active   = 1'b0;
        last_eff = 0;
        held_p   = 0;
        held_c   = 0;
        forever begin
            @(negedge clock);
            n = edge_n;
            while (evt_q.size() > 0 && evt_q[0].eff <= n) begin
                if (evt_q[0].is_reset) begin
                    active = 1'b0;
                    held_p = 0;
                    held_c = 0;
                end else begin
                    active   = 1'b1;
                    last_eff = evt_q[0].eff;
                end
                void'(evt_q.pop_front());
            end
            vexp = (exp_q.size() > 0 && exp_q[0].eff == n);
            if (vexp) begin
                held_p = exp_q[0].p;
                held_c = exp_q[0].c;
                void'(exp_q.pop_front());
            end
            texp = active && ((n - last_eff) >= MAX);
            check("period_valid", n, {31'd0, period_valid}, {31'd0, vexp});
            check("period", n, {3'd0, period}, held_p);
            check("rate_class", n, {30'd0, rate_class}, held_c);
            check("timeout", n, {31'd0, timeout}, {31'd0, texp});
        end
    end

    initial begin : stimulus
        int gap;
        int width;
        pulse_in  = 1'b0;
        reset     = 1'b1;
        prev_v    = 1'b0;
        prev_ok   = 1'b0;
        have_prev = 1'b0;
        last_k    = 0;
        evt_q.push_back('{1'b1, 1});
        do_reset(3);

        // Regular spacing of 15.
        repeat (4) pulse(15, 1);
        idle(5);

        // Spacings 5, 30, 60.
        do_reset(2);
        pulse(5, 1);
        pulse(30, 1);
        pulse(60, 1);
        pulse(5, 1);
        idle(5);

        // Timeout after a lone pulse, recovery, then a 12-cycle period.
        do_reset(2);
        pulse(121, 1);
        pulse(12, 1);
        pulse(5, 1);
        idle(5);

        // Long held level counts once.
        do_reset(2);
        repeat (50) drive(1'b1, 1'b0);
        idle(8);
        pulse(8, 1);
        pulse(8, 1);
        pulse(4, 1);
        idle(5);

        // Reset 7 cycles after an edge.
        do_reset(2);
        repeat (3) pulse(20, 1);
        drive(1'b1, 1'b0);
        idle(6);
        drive(1'b0, 1'b1);
        idle(4);
        pulse(20, 1);
        pulse(20, 1);
        idle(5);

        // Edge exactly at the ceiling, one past it, and the minimum period.
        do_reset(2);
        pulse(100, 1);
        pulse(101, 1);
        pulse(12, 1);
        pulse(2, 1);
        pulse(3, 1);
        idle(5);

        // Input held high across reset release.
        repeat (3) drive(1'b1, 1'b1);
        repeat (10) drive(1'b1, 1'b0);
        idle(4);
        pulse(9, 1);
        pulse(9, 1);
        idle(5);

        // Random spacings and widths.
        do_reset(2);
        repeat (40) begin
            gap   = $urandom_range(115, 2);
            width = $urandom_range(gap - 1, 1);
            pulse(gap, width);
        end
        idle(LAT + 5);

        check("drain", edge_n, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter MAX_PERIOD, default 300000000: count ceiling in clock cycles, at which the meter times out.
REQ-002 SHALL have parameter THRESH_0, default 25000000: the upper bound (exclusive) of rate class 2'b00.
REQ-003 SHALL have parameter THRESH_1, default 75000000: the upper bound (exclusive) of rate class 2'b01.
REQ-004 SHALL have parameter THRESH_2, default 150000000: the upper bound (exclusive) of rate class 2'b10.
REQ-005 SHALL have port clock, input, 1 bit: CLOCK_50, the only clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pulse_in, input, 1 bit: the pulse stream being measured, for example a rate_divider tick or a drum button.
REQ-008 SHALL have port period, output, 29 bits: the last measured edge-to-edge interval, in clock cycles.
REQ-009 SHALL have port period_valid, output, 1 bit: one-cycle strobe that marks an update of period.
REQ-010 SHALL have port rate_class, output, 2 bits: the class of period, using the same speed encoding as rate_divider load_selectors.
REQ-011 SHALL have port timeout, output, 1 bit: high while no rising edge has arrived within MAX_PERIOD cycles.

Function
REQ-012 SHALL detect rising edges as current sample high AND previous sample low; a level held high SHALL count as one edge only.
REQ-013 SHALL implement a state machine with states IDLE (no edge seen yet), MEASURE (counting) and TIMED_OUT.
REQ-014 In IDLE, an edge SHALL go to MEASURE and start the 29-bit counter; no period SHALL be reported.
REQ-015 In MEASURE, the counter SHALL increment every cycle.
REQ-016 In MEASURE, an edge SHALL load period with the cycle distance between this edge and the previous one (edges at sample cycles t0 and t1 give period = t1 - t0).
REQ-017 Together with REQ-016, the same edge SHALL pulse period_valid for exactly one cycle and restart the count for the next interval.
REQ-018 rate_class SHALL update in the same cycle as period: 00 if period < THRESH_0; 01 if period < THRESH_1; 10 if period < THRESH_2; otherwise 11.
REQ-019 In MEASURE, when the count reaches MAX_PERIOD with no edge, the block SHALL go to TIMED_OUT, assert timeout, hold period and rate_class, and not pulse period_valid.
REQ-020 If an edge and count == MAX_PERIOD happen in the same cycle, the edge SHALL win: report period = MAX_PERIOD and stay in MEASURE.
REQ-021 In TIMED_OUT, an edge SHALL deassert timeout on the next cycle, go to MEASURE and restart the count, with no period reported.
REQ-022 The counter SHALL never wrap and SHALL saturate at MAX_PERIOD.
REQ-023 period, period_valid, rate_class and timeout SHALL all be registered outputs.
REQ-024 Edges on consecutive cycles SHALL be impossible by REQ-012; the minimum reportable period SHALL be 2.

Reset
REQ-025 While reset is high at a clock edge: state SHALL be IDLE; counter, period and rate_class SHALL be 0; period_valid and timeout SHALL be 0; the edge and synchroniser history SHALL be 0.
REQ-026 A reset during MEASURE SHALL discard the partial count; the first edge after reset SHALL behave as in IDLE.
REQ-027 If pulse_in is high while reset is released, it SHALL NOT produce an edge.

Configuration
REQ-028 SHALL support the macro PULSE_PERIOD_METER_SYNC_EN.
REQ-029 With PULSE_PERIOD_METER_SYNC_EN defined, pulse_in SHALL pass through a two-flop synchroniser before edge detection; latency from pulse_in first sampled high at clock edge k to period_valid high SHALL be 3 edges (visible after edge k+2).
REQ-030 Without PULSE_PERIOD_METER_SYNC_EN, pulse_in SHALL feed edge detection directly and period_valid SHALL be visible after edge k.
REQ-031 Measured period values SHALL be identical in both configurations.

Verification
REQ-032 Bench SHALL use MAX_PERIOD=100, THRESH_0=10, THRESH_1=20 and THRESH_2=40, and run all scenarios with and without PULSE_PERIOD_METER_SYNC_EN.
REQ-033 Scenario: single-cycle pulses 15 cycles apart -> first pulse gives no valid; each later pulse gives period_valid once, period=15, rate_class=01.
REQ-034 Scenario: pulse spacing 5, then 30, then 60 -> periods 5/30/60, rate_class 00/10/11.
REQ-035 Scenario: one pulse, then 120 idle cycles -> timeout rises 100 cycles after the edge; no valid; the next pulse clears timeout with no valid; a pulse 12 cycles later gives period=12.
REQ-036 Scenario: pulse_in held high for 50 cycles, then pulses every 8 cycles -> the held level counts once; periods 58 then 8.
REQ-037 Scenario: pulses every 20 cycles, reset asserted 7 cycles after an edge -> all outputs 0 next cycle; the next pulse gives no valid; the following pulse gives period=20, rate_class=10.
REQ-038 Scenario: edge arriving exactly at count 100 -> period=100, rate_class=11, timeout stays 0.
